// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - FIFO-buffered word transmitter driving an MSB-first bit-strobed serial line
module serial_word_tx #(
   parameter int HIGH_CYCLES = 10,
   parameter int LOW_CYCLES  = 10,
   parameter int WORD_GAP    = 300,
   parameter int DEPTH       = 4
) (
   input  logic                    clock_1MHz,
   input  logic                    rst,
   input  logic [7:0]              word_in,
   input  logic                    word_valid_in,
   output logic                    word_ready_out,
   input  logic                    status_in,
   output logic                    data_out,
   output logic                    write_out,
   output logic                    busy_out,
   output logic [$clog2(DEPTH):0]  count_out
);

   localparam int AW     = $clog2(DEPTH);
   localparam int MAX_HL = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int MAX_T  = (MAX_HL > WORD_GAP) ? MAX_HL : WORD_GAP;
   localparam int CW     = $clog2(MAX_T) + 1;

   // Timer counts down to zero, so each phase loads its length minus one.
   localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] BIT_HIGH = 2'd1;
   localparam logic [1:0] BIT_LOW  = 2'd2;
   localparam logic [1:0] GAP      = 2'd3;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic [CW-1:0] timer;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;
   logic          push;
   logic          pop;
   logic          timer_done;

   assign word_ready_out = (count < FULL_COUNT);
   assign push           = word_valid_in && word_ready_out;
   assign pop            = (state == IDLE) && (count != '0) && status_in;
   assign timer_done     = (timer == '0);

   assign write_out = (state == BIT_HIGH);
   assign data_out  = ((state == BIT_HIGH) || (state == BIT_LOW)) && shift[7];
   assign busy_out  = (state != IDLE);
   assign count_out = count;

   always_ff @(posedge clock_1MHz) begin
      if (push) begin
         mem[wr_ptr] <= word_in;
      end
   end

   always_ff @(posedge clock_1MHz) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock_1MHz) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         shift   <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift   <= mem[rd_ptr];
                  bit_idx <= 3'd7;
                  timer   <= HIGH_LOAD;
                  state   <= BIT_HIGH;
               end
            end
            BIT_HIGH: begin
               if (timer_done) begin
                  timer <= LOW_LOAD;
                  state <= BIT_LOW;
               end else begin
                  timer <= timer - CW'(1);
               end
            end
            BIT_LOW: begin
               if (!timer_done) begin
                  timer <= timer - CW'(1);
               end else if (bit_idx != 3'd0) begin
                  shift   <= {shift[6:0], 1'b0};
                  bit_idx <= bit_idx - 3'd1;
                  timer   <= HIGH_LOAD;
                  state   <= BIT_HIGH;
               end else if (WORD_GAP == 0) begin
                  state <= IDLE;
               end else begin
                  timer <= GAP_LOAD;
                  state <= GAP;
               end
            end
            default: begin
               if (timer_done) begin
                  state <= IDLE;
               end else begin
                  timer <= timer - CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Transmit-side counterpart of the serial word receiver in `TOP`. It accepts 8-bit words on a parallel valid/ready port and buffers up to DEPTH of them. Each word is sent MSB-first on a one-bit serial line, qualified by a `write_out` strobe, and only when the receiver's `status_in` reports ready. Its outputs drive the receiver's `data_in`/`write_in` pins directly, which replaces hand-written bench stimulus with synthesizable RTL.

## Interface
- HIGH_CYCLES, 10: clocks `write_out` is held high per bit (10 µs at 1 MHz); legal range ≥1.
- LOW_CYCLES, 10: clocks `write_out` is held low after each bit; legal range ≥1.
- WORD_GAP, 300: idle clocks inserted after the 8th bit of each word; legal range ≥0.
- DEPTH, 4: input FIFO entries; must be a power of two, ≥2.
- clock_1MHz  in  1  system clock, 1 MHz.
- rst  in  1  synchronous, active-high reset.
- word_in  in  8  parallel word to transmit.
- word_valid_in  in  1  `word_in` is valid this cycle.
- word_ready_out  out  1  FIFO can accept a word: `count_out < DEPTH`.
- status_in  in  1  receiver ready, level-sensitive.
- data_out  out  1  serial bit, MSB first.
- write_out  out  1  bit strobe; the receiver samples `data_out` while it is high.
- busy_out  out  1  high in any state other than IDLE.
- count_out  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- FIFO push occurs when `word_valid_in && word_ready_out` at a rising edge. A push while full is impossible because ready is low, and `word_in` is ignored.
- FIFO pop happens only on the IDLE→BIT_HIGH transition.
- A push and a pop in the same cycle leave `count_out` unchanged. When the FIFO is full, ready stays low during that cycle; there is no bypass.
- FSM states: IDLE, BIT_HIGH, BIT_LOW, GAP.
  - IDLE: if `count_out != 0 && status_in`, pop the head into an 8-bit shift register, set bit index to 7, and go to BIT_HIGH. Otherwise stay in IDLE.
  - BIT_HIGH: `write_out=1` and `data_out=shift[7]`. After HIGH_CYCLES clocks, go to BIT_LOW.
  - BIT_LOW: `write_out=0` and `data_out` holds the same bit. After LOW_CYCLES clocks:
    - if bit index is 0, go to GAP, or directly to IDLE when WORD_GAP=0;
    - otherwise shift left by one, decrement the index, and go to BIT_HIGH.
  - GAP: `write_out=0` and `data_out=0`. After WORD_GAP clocks, go to IDLE.
- `status_in` is checked only in IDLE. Dropping it mid-word does not abort the word. A word already started always completes all 8 bits.
- Inside IDLE and GAP, `data_out=0`.
- A single down-counter, reloaded on every state entry, times HIGH/LOW/GAP. Its width is $clog2 of the largest of the three parameters, plus 1.

## Timing
- Reset values: `data_out=0`, `write_out=0`, `busy_out=0`, `count_out=0`, `word_ready_out=1`, FSM in IDLE. The FIFO pointers clear, and any in-flight word is discarded.
- `rst` asserted mid-word: on the next edge all outputs take their reset values; nothing resumes after `rst` drops.
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- Start latency: if `status_in=1` and the FIFO is non-empty in IDLE at edge N, then `write_out=1` with `data_out=bit7` from edge N+1.
- A push at edge N into an empty FIFO with `status_in=1` gives: `count_out=1` after N, pop at N+1, `write_out` high after N+1.
- Per-word duration: 8·(HIGH_CYCLES+LOW_CYCLES)+WORD_GAP clocks, then one IDLE decision cycle. With defaults this is 460 clocks plus 1.
- `count_out` updates on the edge after a push or pop.
- FIFO pointers wrap modulo DEPTH.

## Test plan
- Reset values:
  - Stimulus: assert `rst` for 3 clocks with `word_valid_in=1`.
  - Expected: all outputs at reset values throughout, no push, and `count_out=0` after release.
- Single word:
  - Stimulus: push 0x80 with `status_in=1`.
  - Expected: 8 strobes, each 10 high then 10 low; `data_out` sequence 1,0,0,0,0,0,0,0; `busy_out` high for 460 clocks; then IDLE.
- Status gating:
  - Stimulus: push 0xA5 with `status_in=0` for 50 clocks, then raise it.
  - Expected: no strobe while `status_in=0`.
  - Expected: first strobe starts on the cycle after `status_in` rises; bits are 1,0,1,0,0,1,0,1.
- FIFO full and wrap:
  - Stimulus: with `status_in=0`, push 0x80, 0x81, 0x82, 0x83, 0x84.
  - Expected: `count_out=4` and `word_ready_out=0`; 0x84 is not accepted.
  - Stimulus: raise `status_in`.
  - Expected: 0x80–0x83 are sent in order, each followed by the 300-clock gap.
  - Stimulus: push 0x85 and 0x86.
  - Expected: words are sent correctly across the pointer wrap.
- Simultaneous push and pop:
  - Stimulus: FIFO holds 1 word, in IDLE with `status_in=1`; push 0x3C in the same cycle as the pop.
  - Expected: `count_out` stays 1, then 0x3C is transmitted next.
- Mid-word reset and status drop:
  - Stimulus: drop `status_in` during bit 3.
  - Expected: the word completes.
  - Stimulus: assert `rst` during bit 5 of the next word.
  - Expected: `write_out=0` and `count_out=0` on the next edge, with no further strobes.
